wasm_locals_file: RTL and testbench
===================================

Name: wasm_locals_file

Overview:
- Parametrised local-variable store for the wasm CPU; replaces the single fixed locals array behind get_local/set_local/tee_local.
- Adds a stack of call frames: each frame push allocates N zero-initialised locals, and each pop releases them.
- Sits between the CPU decode stage and the operand stack.
- Accepts one op per handshake and returns read results with fixed latency.

Parameters:
- DATA_W, 64, width of a local value (32 allowed when USE_64B is off at CPU level).
- LOCALS_AW, 5, log2 of total local slots shared by all frames.
- FRAME_AW, 3, log2 of maximum nested frames.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  op request.
- op_ready  out  1  block can accept an op this cycle.
- op  in  3  0=GET 1=SET 2=TEE 3=PUSH 4=POP; 5-7 reserved.
- index  in  LOCALS_AW  local index, relative to the current frame.
- nlocals  in  LOCALS_AW+1  local count for PUSH.
- wdata  in  DATA_W  value for SET/TEE.
- wtype  in  2  type for SET/TEE: 0=i32 1=i64 2=f32 3=f64.
- rdata  out  DATA_W  GET/TEE result.
- rtype  out  2  result type.
- rvalid  out  1  one-cycle pulse; rdata/rtype valid.
- frame_depth  out  FRAME_AW+1  number of active frames.
- trap  out  4  0=none 1=index out of range 2=frame overflow 3=frame underflow 4=slots exhausted 5=type mismatch 6=bad op.

Behaviour:
- Reset values: op_ready=0 while reset is asserted, then 1; rvalid=0, rdata=0, rtype=0, frame_depth=0, trap=0, base=0, cur_n=0, FSM=IDLE.
- Reset asserted mid-CLEAR aborts the clear immediately.
- An op is accepted on a clk edge with op_valid & op_ready.
- FSM states: IDLE, CLEAR, TRAP.
- GET: if index >= cur_n, trap=1. Otherwise rdata/rtype = slot[base+index], rvalid pulses exactly 1 cycle after acceptance. op_ready stays 1, so back-to-back GETs give one result per cycle.
- SET: if index >= cur_n, trap=1. Otherwise writes wdata/wtype to slot[base+index]; no rvalid.
- TEE: performs the SET write and, 1 cycle after acceptance, pulses rvalid with rdata=wdata, rtype=wtype (forwarded, not read back).
- Read/write ordering: a GET accepted the cycle after a SET/TEE to the same slot returns the new value.
- PUSH:
  - If frame_depth == 2**FRAME_AW, trap=2.
  - Else if base+cur_n+nlocals > 2**LOCALS_AW, trap=4.
  - Else push {base,cur_n} to the frame stack, set base += cur_n, cur_n = nlocals, frame_depth++.
  - Then enter CLEAR: one slot per cycle, value 0, type i32, typed flag cleared. op_ready=0 throughout.
  - Return to IDLE after exactly nlocals cycles. nlocals=0 skips CLEAR; op_ready stays 1.
- POP: if frame_depth == 0, trap=3. Otherwise restore {base,cur_n} from the stack and decrement frame_depth, all in 1 cycle.
- Arithmetic: slot address = base+index, LOCALS_AW bits; in-range operands never wrap. The overflow check uses LOCALS_AW+2-bit sums.
- Any trap condition, including op 5-7 (trap=6):
  - the op has no side effect;
  - trap latches the code and the FSM moves to TRAP;
  - op_ready=0 and rvalid=0 until reset; trap is sticky.
  - If several conditions are true at once, the lowest-numbered code wins.
- Operations outside the current frame are impossible by construction; an index in the caller's frame still traps 1.

Optional Feature:
- Macro: WASM_LOCALS_TYPECHECK_EN.
- Defined:
  - each slot holds a typed flag, cleared by CLEAR;
  - the first SET/TEE to a slot sets the flag and fixes the type;
  - a later SET/TEE with a different wtype raises trap=5 with no write;
  - GET of an untyped slot returns 0 with type i32.
- Undefined: no typed flag storage; SET/TEE always overwrite the type; code 5 never occurs.

Test Plan:
- Reset, PUSH nlocals=3 -> op_ready low 3 cycles, frame_depth=1. Then GET idx2 -> rvalid next cycle, rdata=0, rtype=0.
- PUSH 1, TEE idx0 wdata=2 wtype=1 -> rvalid 1 cycle later, rdata=2, rtype=i64. Next GET idx0 -> rdata=2, rtype=1.
- Nesting: PUSH 2, SET idx1=7, PUSH 2, SET idx1=9, POP, GET idx1 -> rdata=7; frame_depth goes 1,2,1.
- Boundaries:
  - GET idx=cur_n -> trap=1, op_ready stuck 0;
  - POP at depth 0 -> trap=3;
  - 2**FRAME_AW+1 PUSHes of 0 -> trap=2;
  - PUSH 33 with LOCALS_AW=5 -> trap=4;
  - reset clears each.
- Assert reset during CLEAR of PUSH 20 -> all outputs return to reset values; a following PUSH 1 + GET returns 0.
- TYPECHECK_EN: SET idx0 i32 5, then SET idx0 f64 -> trap=5 and the slot keeps 5. With the macro off -> no trap; GET returns the f64 value.

Source files
------------

// File: rtl/wasm_locals_file_if.sv
// Op/result bus of the wasm locals file.
// master: CPU decode side (drives ops); slave: the locals file.
interface wasm_locals_file_if #(
    parameter int DATA_W    = 64,
    parameter int LOCALS_AW = 5,
    parameter int FRAME_AW  = 3
);
    logic                 op_valid;
    logic                 op_ready;
    logic [2:0]           op;
    logic [LOCALS_AW-1:0] index;
    logic [LOCALS_AW:0]   nlocals;
    logic [DATA_W-1:0]    wdata;
    logic [1:0]           wtype;
    logic [DATA_W-1:0]    rdata;
    logic [1:0]           rtype;
    logic                 rvalid;
    logic [FRAME_AW:0]    frame_depth;
    logic [3:0]           trap;

    modport master (
        output op_valid, op, index, nlocals, wdata, wtype,
        input  op_ready, rdata, rtype, rvalid, frame_depth, trap
    );

    modport slave (
        input  op_valid, op, index, nlocals, wdata, wtype,
        output op_ready, rdata, rtype, rvalid, frame_depth, trap
    );
endinterface

// File: rtl/wasm_locals_file.sv
// wasm_locals_file: framed local-variable store for the wasm CPU.
// Each PUSH opens a frame of nlocals zeroed slots (cleared one per cycle),
// POP restores the caller's frame. Any illegal op latches a sticky trap.
// Optional macro WASM_LOCALS_TYPECHECK_EN adds per-slot type locking.
module wasm_locals_file #(
    parameter int DATA_W    = 64,
    parameter int LOCALS_AW = 5,
    parameter int FRAME_AW  = 3
) (
    input  logic              clk,
    input  logic              reset,
    wasm_locals_file_if.slave bus
);
    localparam int SLOTS  = 1 << LOCALS_AW;
    localparam int FRAMES = 1 << FRAME_AW;
    localparam logic [FRAME_AW:0]    DEPTH_MAX = (FRAME_AW+1)'(FRAMES);
    localparam logic [LOCALS_AW+1:0] SLOT_LIM  = (LOCALS_AW+2)'(SLOTS);

    localparam logic [2:0] OP_GET  = 3'd0;
    localparam logic [2:0] OP_SET  = 3'd1;
    localparam logic [2:0] OP_TEE  = 3'd2;
    localparam logic [2:0] OP_PUSH = 3'd3;
    localparam logic [2:0] OP_POP  = 3'd4;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CLEAR = 2'd1, ST_TRAP = 2'd2} state_t;

    state_t               state_q, state_d;
    logic                 op_ready_q, op_ready_d;
    logic                 rvalid_q, rvalid_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [1:0]           rtype_q, rtype_d;
    logic [FRAME_AW:0]    frame_depth_q, frame_depth_d;
    logic [3:0]           trap_q, trap_d;
    logic [LOCALS_AW:0]   base_q, base_d;
    logic [LOCALS_AW:0]   cur_n_q, cur_n_d;
    logic [LOCALS_AW-1:0] clear_addr_q, clear_addr_d;
    logic [LOCALS_AW:0]   clear_cnt_q, clear_cnt_d;

    logic [DATA_W-1:0]    slot_data_q [SLOTS];
    logic [1:0]           slot_type_q [SLOTS];
    logic [LOCALS_AW:0]   stk_base_q  [FRAMES];
    logic [LOCALS_AW:0]   stk_n_q     [FRAMES];

    logic                 wr_en_s;
    logic [LOCALS_AW-1:0] wr_addr_s;
    logic [DATA_W-1:0]    wr_data_s;
    logic [1:0]           wr_type_s;
    logic                 stk_we_s;

    logic                 accept_s;
    logic [LOCALS_AW:0]   addr_sum_s;
    logic [LOCALS_AW-1:0] slot_addr_s;
    logic                 idx_oob_s;
    logic [LOCALS_AW+1:0] push_sum_s;
    logic [LOCALS_AW:0]   new_base_s;
    logic [FRAME_AW:0]    depth_m1_s;
    logic                 type_mm_s;
    logic [DATA_W-1:0]    rd_data_s;
    logic [1:0]           rd_type_s;
    logic [3:0]           trap_code_s;

`ifdef WASM_LOCALS_TYPECHECK_EN
    logic                 slot_typed_q [SLOTS];
    logic                 wr_typed_s;
`endif

    assign accept_s    = bus.op_valid & op_ready_q;
    assign addr_sum_s  = base_q + {1'b0, bus.index};
    assign slot_addr_s = addr_sum_s[LOCALS_AW-1:0];
    assign idx_oob_s   = ({1'b0, bus.index} >= cur_n_q);
    assign push_sum_s  = {1'b0, base_q} + {1'b0, cur_n_q} + {1'b0, bus.nlocals};
    assign new_base_s  = base_q + cur_n_q;
    assign depth_m1_s  = frame_depth_q - (FRAME_AW+1)'(1);

`ifdef WASM_LOCALS_TYPECHECK_EN
    assign type_mm_s = slot_typed_q[slot_addr_s] & (slot_type_q[slot_addr_s] != bus.wtype);
    assign rd_data_s = slot_typed_q[slot_addr_s] ? slot_data_q[slot_addr_s] : {DATA_W{1'b0}};
    assign rd_type_s = slot_typed_q[slot_addr_s] ? slot_type_q[slot_addr_s] : 2'd0;
`else
    assign type_mm_s = 1'b0;
    assign rd_data_s = slot_data_q[slot_addr_s];
    assign rd_type_s = slot_type_q[slot_addr_s];
`endif

    // Trap classification of the presented op; lowest code wins on overlap.
    always_comb begin
        trap_code_s = 4'd0;
        case (bus.op)
            OP_GET:         trap_code_s = idx_oob_s ? 4'd1 : 4'd0;
            OP_SET, OP_TEE: trap_code_s = idx_oob_s ? 4'd1 : (type_mm_s ? 4'd5 : 4'd0);
            OP_PUSH:        trap_code_s = (frame_depth_q == DEPTH_MAX) ? 4'd2 :
                                          ((push_sum_s > SLOT_LIM) ? 4'd4 : 4'd0);
            OP_POP:         trap_code_s = (frame_depth_q == {(FRAME_AW+1){1'b0}}) ? 4'd3 : 4'd0;
            default:        trap_code_s = 4'd6;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && (trap_code_s != 4'd0)) begin
                    state_d = ST_TRAP;
                end else if (accept_s && (bus.op == OP_PUSH) && (bus.nlocals != {(LOCALS_AW+1){1'b0}})) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: state_d = (clear_cnt_q == (LOCALS_AW+1)'(1)) ? ST_IDLE : ST_CLEAR;
            ST_TRAP:  state_d = ST_TRAP;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM output and datapath next values, slot/stack write strobes.
    always_comb begin
        op_ready_d    = (state_d == ST_IDLE);
        rvalid_d      = 1'b0;
        rdata_d       = rdata_q;
        rtype_d       = rtype_q;
        frame_depth_d = frame_depth_q;
        trap_d        = trap_q;
        base_d        = base_q;
        cur_n_d       = cur_n_q;
        clear_addr_d  = clear_addr_q;
        clear_cnt_d   = clear_cnt_q;
        wr_en_s       = 1'b0;
        wr_addr_s     = slot_addr_s;
        wr_data_s     = bus.wdata;
        wr_type_s     = bus.wtype;
        stk_we_s      = 1'b0;
`ifdef WASM_LOCALS_TYPECHECK_EN
        wr_typed_s    = 1'b1;
`endif
        if ((state_q == ST_IDLE) && accept_s) begin
            if (trap_code_s != 4'd0) begin
                trap_d = trap_code_s;
            end else begin
                case (bus.op)
                    OP_GET: begin
                        rvalid_d = 1'b1;
                        rdata_d  = rd_data_s;
                        rtype_d  = rd_type_s;
                    end
                    OP_SET: wr_en_s = 1'b1;
                    OP_TEE: begin
                        wr_en_s  = 1'b1;
                        rvalid_d = 1'b1;
                        rdata_d  = bus.wdata;
                        rtype_d  = bus.wtype;
                    end
                    OP_PUSH: begin
                        stk_we_s      = 1'b1;
                        base_d        = new_base_s;
                        cur_n_d       = bus.nlocals;
                        frame_depth_d = frame_depth_q + (FRAME_AW+1)'(1);
                        clear_addr_d  = new_base_s[LOCALS_AW-1:0];
                        clear_cnt_d   = bus.nlocals;
                    end
                    OP_POP: begin
                        base_d        = stk_base_q[depth_m1_s[FRAME_AW-1:0]];
                        cur_n_d       = stk_n_q[depth_m1_s[FRAME_AW-1:0]];
                        frame_depth_d = depth_m1_s;
                    end
                    default: rvalid_d = 1'b0;
                endcase
            end
        end else if (state_q == ST_CLEAR) begin
            wr_en_s      = 1'b1;
            wr_addr_s    = clear_addr_q;
            wr_data_s    = {DATA_W{1'b0}};
            wr_type_s    = 2'd0;
`ifdef WASM_LOCALS_TYPECHECK_EN
            wr_typed_s   = 1'b0;
`endif
            clear_addr_d = clear_addr_q + (LOCALS_AW)'(1);
            clear_cnt_d  = clear_cnt_q - (LOCALS_AW+1)'(1);
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Control/output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_ready_q    <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= {DATA_W{1'b0}};
            rtype_q       <= 2'd0;
            frame_depth_q <= {(FRAME_AW+1){1'b0}};
            trap_q        <= 4'd0;
            base_q        <= {(LOCALS_AW+1){1'b0}};
            cur_n_q       <= {(LOCALS_AW+1){1'b0}};
            clear_addr_q  <= {LOCALS_AW{1'b0}};
            clear_cnt_q   <= {(LOCALS_AW+1){1'b0}};
        end else begin
            op_ready_q    <= op_ready_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            rtype_q       <= rtype_d;
            frame_depth_q <= frame_depth_d;
            trap_q        <= trap_d;
            base_q        <= base_d;
            cur_n_q       <= cur_n_d;
            clear_addr_q  <= clear_addr_d;
            clear_cnt_q   <= clear_cnt_d;
        end
    end

    // Slot storage: single write port shared by SET/TEE and the clear walker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SLOTS; i++) begin
                slot_data_q[i]  <= {DATA_W{1'b0}};
                slot_type_q[i]  <= 2'd0;
`ifdef WASM_LOCALS_TYPECHECK_EN
                slot_typed_q[i] <= 1'b0;
`endif
            end
        end else if (wr_en_s) begin
            slot_data_q[wr_addr_s]  <= wr_data_s;
            slot_type_q[wr_addr_s]  <= wr_type_s;
`ifdef WASM_LOCALS_TYPECHECK_EN
            slot_typed_q[wr_addr_s] <= wr_typed_s;
`endif
        end else begin
            slot_data_q[wr_addr_s]  <= slot_data_q[wr_addr_s];
        end
    end

    // Frame stack: saves the caller's {base, cur_n} on PUSH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FRAMES; i++) begin
                stk_base_q[i] <= {(LOCALS_AW+1){1'b0}};
                stk_n_q[i]    <= {(LOCALS_AW+1){1'b0}};
            end
        end else if (stk_we_s) begin
            stk_base_q[frame_depth_q[FRAME_AW-1:0]] <= base_q;
            stk_n_q[frame_depth_q[FRAME_AW-1:0]]    <= cur_n_q;
        end else begin
            stk_base_q[0] <= stk_base_q[0];
        end
    end

    assign bus.op_ready    = op_ready_q;
    assign bus.rvalid      = rvalid_q;
    assign bus.rdata       = rdata_q;
    assign bus.rtype       = rtype_q;
    assign bus.frame_depth = frame_depth_q;
    assign bus.trap        = trap_q;
endmodule

// File: tb/tb_wasm_locals_file.sv
// Directed, table-driven bench for wasm_locals_file.
module tb_wasm_locals_file;
    localparam int DATA_W    = 64;
    localparam int LOCALS_AW = 5;
    localparam int FRAME_AW  = 3;
    localparam logic [63:0] F64_VAL = 64'h4014_0000_0000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wasm_locals_file_if #(.DATA_W(DATA_W), .LOCALS_AW(LOCALS_AW), .FRAME_AW(FRAME_AW)) bus();

    wasm_locals_file #(.DATA_W(DATA_W), .LOCALS_AW(LOCALS_AW), .FRAME_AW(FRAME_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          rst;
        logic [2:0]  op;
        logic [4:0]  idx;
        logic [5:0]  nl;
        logic [63:0] wd;
        logic [1:0]  wt;
        bit          e_rv;
        logic [63:0] e_rd;
        logic [1:0]  e_rt;
        logic [3:0]  e_dep;
        logic [3:0]  e_trap;
        int          e_busy;
    } vec_t;

    vec_t vecs[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(bit rst, logic [2:0] op, logic [4:0] idx, logic [5:0] nl,
                                logic [63:0] wd, logic [1:0] wt, bit rv, logic [63:0] rd,
                                logic [1:0] rt, logic [3:0] dep, logic [3:0] tr, int busy);
        vec_t v;
        v.rst = rst; v.op = op; v.idx = idx; v.nl = nl; v.wd = wd; v.wt = wt;
        v.e_rv = rv; v.e_rd = rd; v.e_rt = rt; v.e_dep = dep; v.e_trap = tr; v.e_busy = busy;
        vecs.push_back(v);
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_op_ready"}, {63'd0, bus.op_ready}, 64'd0);
        check({tag, "_rvalid"}, {63'd0, bus.rvalid}, 64'd0);
        check({tag, "_rdata"}, bus.rdata, 64'd0);
        check({tag, "_rtype"}, {62'd0, bus.rtype}, 64'd0);
        check({tag, "_depth"}, {60'd0, bus.frame_depth}, 64'd0);
        check({tag, "_trap"}, {60'd0, bus.trap}, 64'd0);
    endtask

    task automatic do_reset();
        bus.op_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_reset", {63'd0, bus.op_ready}, 64'd1);
    endtask

    task automatic apply(input int n, input vec_t v);
        int cyc;
        if (v.rst) do_reset();
        @(negedge clk);
        bus.op = v.op; bus.index = v.idx; bus.nlocals = v.nl;
        bus.wdata = v.wd; bus.wtype = v.wt; bus.op_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        check($sformatf("v%0d_rvalid", n), {63'd0, bus.rvalid}, {63'd0, v.e_rv});
        if (v.e_rv) begin
            check($sformatf("v%0d_rdata", n), bus.rdata, v.e_rd);
            check($sformatf("v%0d_rtype", n), {62'd0, bus.rtype}, {62'd0, v.e_rt});
        end
        check($sformatf("v%0d_depth", n), {60'd0, bus.frame_depth}, {60'd0, v.e_dep});
        check($sformatf("v%0d_trap", n), {60'd0, bus.trap}, {60'd0, v.e_trap});
        if (v.e_trap != 4'd0) begin
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("v%0d_trap_ready_stuck", n), {63'd0, bus.op_ready}, 64'd0);
            check($sformatf("v%0d_trap_sticky", n), {60'd0, bus.trap}, {60'd0, v.e_trap});
            check($sformatf("v%0d_trap_no_rvalid", n), {63'd0, bus.rvalid}, 64'd0);
        end else begin
            cyc = 0;
            while ((bus.op_ready !== 1'b1) && (cyc < 64)) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            check($sformatf("v%0d_busy_cycles", n), cyc, v.e_busy);
            if (v.e_rv) begin
                @(posedge clk);
                #1;
                check($sformatf("v%0d_rvalid_pulse_end", n), {63'd0, bus.rvalid}, 64'd0);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bus.op_valid = 1'b0; bus.op = 3'd0; bus.index = 5'd0; bus.nlocals = 6'd0;
        bus.wdata = 64'd0; bus.wtype = 2'd0;

        //   rst op idx nl wdata    wt  rv rdata    rt dep trap busy
        add(1, 3, 0, 3,  64'd0,   0,  0, 64'd0,   0, 1,  0,   3);
        add(0, 0, 2, 0,  64'd0,   0,  1, 64'd0,   0, 1,  0,   0);
        add(0, 3, 0, 1,  64'd0,   0,  0, 64'd0,   0, 2,  0,   1);
        add(0, 2, 0, 0,  64'd2,   1,  1, 64'd2,   1, 2,  0,   0);
        add(0, 0, 0, 0,  64'd0,   0,  1, 64'd2,   1, 2,  0,   0);
        add(0, 4, 0, 0,  64'd0,   0,  0, 64'd0,   0, 1,  0,   0);
        add(0, 3, 0, 2,  64'd0,   0,  0, 64'd0,   0, 2,  0,   2);
        add(0, 0, 0, 0,  64'd0,   0,  1, 64'd0,   0, 2,  0,   0);
        add(0, 1, 1, 0,  64'd7,   1,  0, 64'd0,   0, 2,  0,   0);
        add(0, 3, 0, 2,  64'd0,   0,  0, 64'd0,   0, 3,  0,   2);
        add(0, 1, 1, 0,  64'd9,   1,  0, 64'd0,   0, 3,  0,   0);
        add(0, 0, 1, 0,  64'd0,   0,  1, 64'd9,   1, 3,  0,   0);
        add(0, 4, 0, 0,  64'd0,   0,  0, 64'd0,   0, 2,  0,   0);
        add(0, 0, 1, 0,  64'd0,   0,  1, 64'd7,   1, 2,  0,   0);
        add(0, 1, 0, 0,  64'd5,   0,  0, 64'd0,   0, 2,  0,   0);
`ifdef WASM_LOCALS_TYPECHECK_EN
        add(0, 1, 0, 0,  F64_VAL, 3,  0, 64'd0,   0, 2,  5,   0);
`else
        add(0, 1, 0, 0,  F64_VAL, 3,  0, 64'd0,   0, 2,  0,   0);
        add(0, 0, 0, 0,  64'd0,   0,  1, F64_VAL, 3, 2,  0,   0);
`endif
        // index == cur_n
        add(1, 3, 0, 2,  64'd0,   0,  0, 64'd0,   0, 1,  0,   2);
        add(0, 0, 2, 0,  64'd0,   0,  0, 64'd0,   0, 1,  1,   0);
        // pop with no frames
        add(1, 4, 0, 0,  64'd0,   0,  0, 64'd0,   0, 0,  3,   0);
        // frame overflow after 8 empty frames
        for (int k = 1; k <= 8; k++) begin
            add(k == 1, 3, 0, 0, 64'd0, 0, 0, 64'd0, 0, 4'(k), 0, 0);
        end
        add(0, 3, 0, 0,  64'd0,   0,  0, 64'd0,   0, 8,  2,   0);
        // slot exhaustion
        add(1, 3, 0, 33, 64'd0,   0,  0, 64'd0,   0, 0,  4,   0);
        add(1, 3, 0, 32, 64'd0,   0,  0, 64'd0,   0, 1,  0,   32);
        add(0, 3, 0, 1,  64'd0,   0,  0, 64'd0,   0, 1,  4,   0);
        // reserved opcode
        add(1, 5, 0, 0,  64'd0,   0,  0, 64'd0,   0, 0,  6,   0);

        foreach (vecs[i]) apply(i, vecs[i]);

        // Back-to-back ops with op_valid held: SET then GET of same slot, two GETs in a row.
        do_reset();
        v = '{rst: 1'b0, op: 3'd3, idx: 5'd0, nl: 6'd2, wd: 64'd0, wt: 2'd0,
              e_rv: 1'b0, e_rd: 64'd0, e_rt: 2'd0, e_dep: 4'd1, e_trap: 4'd0, e_busy: 2};
        apply(100, v);
        begin
            logic [2:0]  sq_op [5] = '{3'd1, 3'd0, 3'd1, 3'd0, 3'd0};
            logic [4:0]  sq_ix [5] = '{5'd0, 5'd0, 5'd1, 5'd1, 5'd0};
            logic [63:0] sq_wd [5] = '{64'd11, 64'd0, 64'd22, 64'd0, 64'd0};
            logic [1:0]  sq_wt [5] = '{2'd2, 2'd0, 2'd1, 2'd0, 2'd0};
            bit          sq_rv [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
            logic [63:0] sq_rd [5] = '{64'd0, 64'd11, 64'd0, 64'd22, 64'd11};
            logic [1:0]  sq_rt [5] = '{2'd0, 2'd2, 2'd0, 2'd1, 2'd2};
            for (int s = 0; s < 5; s++) begin
                @(negedge clk);
                bus.op = sq_op[s]; bus.index = sq_ix[s]; bus.wdata = sq_wd[s];
                bus.wtype = sq_wt[s]; bus.nlocals = 6'd0; bus.op_valid = 1'b1;
                @(posedge clk);
                #1;
                check($sformatf("b2b%0d_rvalid", s), {63'd0, bus.rvalid}, {63'd0, sq_rv[s]});
                if (sq_rv[s]) begin
                    check($sformatf("b2b%0d_rdata", s), bus.rdata, sq_rd[s]);
                    check($sformatf("b2b%0d_rtype", s), {62'd0, bus.rtype}, {62'd0, sq_rt[s]});
                end
            end
            bus.op_valid = 1'b0;
        end

        // Reset asserted in the middle of a 20-slot clear.
        do_reset();
        @(negedge clk);
        bus.op = 3'd3; bus.index = 5'd0; bus.nlocals = 6'd20; bus.op_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midclear_busy", {63'd0, bus.op_ready}, 64'd0);
        check("midclear_depth", {60'd0, bus.frame_depth}, 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_vals("midclear_async");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midclear_ready_after", {63'd0, bus.op_ready}, 64'd1);
        v = '{rst: 1'b0, op: 3'd3, idx: 5'd0, nl: 6'd1, wd: 64'd0, wt: 2'd0,
              e_rv: 1'b0, e_rd: 64'd0, e_rt: 2'd0, e_dep: 4'd1, e_trap: 4'd0, e_busy: 1};
        apply(200, v);
        v = '{rst: 1'b0, op: 3'd0, idx: 5'd0, nl: 6'd0, wd: 64'd0, wt: 2'd0,
              e_rv: 1'b1, e_rd: 64'd0, e_rt: 2'd0, e_dep: 4'd1, e_trap: 4'd0, e_busy: 0};
        apply(201, v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
